addsub_pipe: RTL and testbench

//  Parametrised, pipelined two's-complement adder/subtractor.

---
 rtl/addsub_pipe.sv | 123 ++++++++++++
 tb/tb_addsub_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor: result = a + (b ^ {WIDTH{s}}) + cin,
// resolved CHUNK bits per stage with valid/ready handshakes and result flags.
module addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NSTG = WIDTH / CHUNK;

    logic w_stall;
    logic w_adv;

    // A single global enable: a stalled output freezes every stage, so bubbles stay in place.
    assign w_stall  = out_valid & ~out_ready;
    assign w_adv    = ~w_stall;
    assign in_ready = w_adv;

    genvar k;
    generate
        for (k = 0; k < NSTG; k++) begin : g_stg
            localparam int LO = k * CHUNK;
            localparam int HI = WIDTH - LO;

            logic [HI-1:0]       w_a_in;
            logic [HI-1:0]       w_b_in;
            logic                w_c_in;
            logic                w_v_in;
            logic [CHUNK:0]      w_chunk;
            logic [LO+CHUNK-1:0] w_lo_new;
            logic                r_v;
            logic                r_c;
            logic [LO+CHUNK-1:0] r_lo;

            if (k == 0) begin : g_first
                assign w_a_in   = a;
                assign w_b_in   = b ^ {WIDTH{s}};
                assign w_c_in   = cin;
                assign w_v_in   = in_valid;
                assign w_lo_new = w_chunk[CHUNK-1:0];
            end else begin : g_next
                assign w_a_in   = g_stg[k-1].g_hi.r_a;
                assign w_b_in   = g_stg[k-1].g_hi.r_b;
                assign w_c_in   = g_stg[k-1].r_c;
                assign w_v_in   = g_stg[k-1].r_v;
                assign w_lo_new = {w_chunk[CHUNK-1:0], g_stg[k-1].r_lo};
            end

            assign w_chunk = {1'b0, w_a_in[CHUNK-1:0]} + {1'b0, w_b_in[CHUNK-1:0]}
                           + {{CHUNK{1'b0}}, w_c_in};

            // Stage valid, chunk carry and the growing block of finished low sum bits.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v  <= 1'b0;
                    r_c  <= 1'b0;
                    r_lo <= {(LO+CHUNK){1'b0}};
                end else if (w_adv) begin
                    r_v  <= w_v_in;
                    r_c  <= w_chunk[CHUNK];
                    r_lo <= w_lo_new;
                end
            end

            if (k < NSTG - 1) begin : g_hi
                logic [HI-CHUNK-1:0] r_a;
                logic [HI-CHUNK-1:0] r_b;

                // Skew registers: operand bits still waiting for a later stage.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_a <= {(HI-CHUNK){1'b0}};
                        r_b <= {(HI-CHUNK){1'b0}};
                    end else if (w_adv) begin
                        r_a <= w_a_in[HI-1:CHUNK];
                        r_b <= w_b_in[HI-1:CHUNK];
                    end
                end
            end else begin : g_flg
                logic w_cmsb;
                logic r_ovf;
                logic r_zero;

                // Carry into the MSB recovered from the MSB's own sum bit.
                assign w_cmsb = w_a_in[CHUNK-1] ^ w_b_in[CHUNK-1] ^ w_chunk[CHUNK-1];

                // Flags of the final stage, registered alongside the result.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_ovf  <= 1'b0;
                        r_zero <= 1'b0;
                    end else if (w_adv) begin
                        r_ovf  <= w_cmsb ^ w_chunk[CHUNK];
                        r_zero <= ~|w_lo_new;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stg[NSTG-1].r_v;
    assign sum       = g_stg[NSTG-1].r_lo;
    assign cout      = g_stg[NSTG-1].r_c;
    assign ovf       = g_stg[NSTG-1].g_flg.r_ovf;
    assign zero      = g_stg[NSTG-1].g_flg.r_zero;
    assign neg       = sum[WIDTH-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: directed table, stall/bubble/reset sequences
// on a 16/4 instance, and randomized sweeps on 8/8, 16/4 and 32/8 instances.
module tb_addsub_pipe;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic        cin;
        logic [15:0] e_sum;
        logic        e_cout;
        logic        e_ovf;
        logic        e_zero;
        logic        e_neg;
    } vec_t;

    localparam int NRND = 13500;

    int n_chk = 0;
    int n_err = 0;
    int n_out = 0;

    logic clk;
    logic rst_n;
    logic rst_h_n;

    logic        in_valid, in_ready, cin, s, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        cout, ovf, zero, neg;
    exp_t        mq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .s(s), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
    );

    // Reference: plain integer arithmetic, overflow from the signed range.
    function automatic exp_t ref_calc(input int w, input longint va, input longint vb,
                                      input bit vs, input bit vc);
        longint m, half, ua, bx, full, sa, sb, sv;
        exp_t   r;
        m      = (64'sd1 <<< w) - 64'sd1;
        half   = 64'sd1 <<< (w - 1);
        ua     = va & m;
        bx     = vs ? (~vb & m) : (vb & m);
        full   = ua + bx + longint'(vc);
        sa     = (ua >= half) ? ua - (m + 64'sd1) : ua;
        sb     = (bx >= half) ? bx - (m + 64'sd1) : bx;
        sv     = sa + sb + longint'(vc);
        r.sum  = 32'(full & m);
        r.cout = ((full >>> w) & 64'sd1) != 64'sd0;
        r.ovf  = (sv >= half) || (sv < -half);
        r.zero = (full & m) == 64'sd0;
        r.neg  = ((full >>> (w - 1)) & 64'sd1) != 64'sd0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic chk_res(input string nm, input exp_t e, input logic [31:0] gsum,
                           input logic gc, input logic go, input logic gz, input logic gn);
        chk({nm, "_sum"}, gsum, e.sum);
        chk({nm, "_flags"}, {28'd0, gc, go, gz, gn}, {28'd0, e.cout, e.ovf, e.zero, e.neg});
    endtask

    // One clock: drive after the edge, sample once inputs have settled, score transfers.
    task automatic cyc(input logic v, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic ts, input logic tc, input logic ordy);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid  = v;
        a         = ta;
        b         = tb_;
        s         = ts;
        cin       = tc;
        out_ready = ordy;
        #1;
        if (in_valid && in_ready) mq.push_back(ref_calc(16, longint'(ta), longint'(tb_), ts, tc));
        if (out_valid && out_ready) begin
            n_out++;
            if (mq.size() == 0) begin
                chk("stream_spurious", {31'd0, out_valid}, 32'd0);
            end else begin
                e = mq.pop_front();
                chk_res("stream", e, {16'd0, sum}, cout, ovf, zero, neg);
            end
        end
    endtask

    generate
        for (genvar g = 0; g < 3; g++) begin : g_rnd
            localparam int HW = (g == 0) ? 8 : ((g == 1) ? 16 : 32);
            localparam int HC = (g == 0) ? 8 : ((g == 1) ? 4 : 8);
            logic [HW-1:0] ha, hb, hsum;
            logic          hcin, hs, hv, hir, hov, hrdy, hco, hovf, hz, hn;
            logic          done;
            exp_t          hq[$];

            addsub_pipe #(.WIDTH(HW), .CHUNK(HC)) u_dut (
                .clk(clk), .rst_n(rst_h_n), .in_valid(hv), .in_ready(hir),
                .a(ha), .b(hb), .cin(hcin), .s(hs), .out_valid(hov), .out_ready(hrdy),
                .sum(hsum), .cout(hco), .ovf(hovf), .zero(hz), .neg(hn)
            );

            initial begin
                exp_t e;
                done = 1'b0;
                hv   = 1'b0;
                hrdy = 1'b0;
                ha   = HW'(0);
                hb   = HW'(0);
                hs   = 1'b0;
                hcin = 1'b0;
                wait (rst_h_n === 1'b1);
                for (int t = 0; t < NRND + 64; t++) begin
                    @(posedge clk);
                    #1;
                    hv   = (t < NRND) && ($urandom_range(3, 0) != 0);
                    ha   = HW'($urandom());
                    hb   = HW'($urandom());
                    hs   = 1'($urandom());
                    hcin = 1'($urandom());
                    hrdy = (t >= NRND) || ($urandom_range(3, 0) != 0);
                    #1;
                    if (hv && hir) hq.push_back(ref_calc(HW, longint'(ha), longint'(hb), hs, hcin));
                    if (hov && hrdy) begin
                        if (hq.size() == 0) begin
                            chk($sformatf("rnd%0d_spurious", HW), {31'd0, hov}, 32'd0);
                        end else begin
                            e = hq.pop_front();
                            chk_res($sformatf("rnd%0d", HW), e, 32'(hsum), hco, hovf, hz, hn);
                        end
                    end
                end
                chk($sformatf("rnd%0d_left", HW), hq.size(), 32'd0);
                done = 1'b1;
            end
        end
    endgenerate

    initial begin
        vec_t tbl[10];
        int   issued, low_cnt, base;
        logic all_done;

        tbl[0] = '{16'h0007, 16'h0003, 1'b0, 1'b0, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'h0007, 16'h0003, 1'b1, 1'b1, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{16'h1234, 16'h0FFF, 1'b0, 1'b1, 16'h2234, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n     = 1'b0;
        rst_h_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'd0;
        b         = 16'd0;
        s         = 1'b0;
        cin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_flags", {28'd0, cout, ovf, zero, neg}, 32'd0);
        #1;
        rst_n   = 1'b1;
        rst_h_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed table: each op issued alone, result expected in the 4th cycle after issue.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].cin, 1'b1);
            for (int j = 1; j <= 4; j++) begin
                cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
                chk($sformatf("lat%0d_%0d", i, j), {31'd0, out_valid}, 32'(j == 4));
                if (j == 4) begin
                    chk($sformatf("tbl%0d_sum", i), {16'd0, sum}, {16'd0, tbl[i].e_sum});
                    chk($sformatf("tbl%0d_flags", i), {28'd0, cout, ovf, zero, neg},
                        {28'd0, tbl[i].e_cout, tbl[i].e_ovf, tbl[i].e_zero, tbl[i].e_neg});
                end
            end
        end

        // Eight back-to-back ops with out_ready dropped for three cycles.
        issued  = 0;
        low_cnt = 0;
        base    = n_out;
        for (int t = 0; t < 24; t++) begin
            cyc(issued < 8, 16'($urandom()), 16'($urandom()), 1'($urandom()), 1'($urandom()),
                !(t >= 5 && t <= 7));
            if (in_valid && in_ready) issued++;
            if (!in_ready) low_cnt++;
            if (t >= 4 && t <= 8) chk($sformatf("stall_ready_t%0d", t), {31'd0, in_ready},
                                      32'(!(t >= 5 && t <= 7)));
        end
        chk("stall_low_cycles", low_cnt, 32'd3);
        chk("stall_out_count", n_out - base, 32'd8);
        chk("stall_queue_left", mq.size(), 32'd0);

        // Alternating issue with alternating mode: bubbles must come out where they went in.
        for (int t = 0; t < 20; t++) begin
            cyc((t < 12) && (t % 2 == 0), 16'($urandom()), 16'($urandom()),
                1'((t / 2) % 2), 1'((t / 2) % 2), 1'b1);
            chk($sformatf("bubble_t%0d", t), {31'd0, out_valid},
                32'((t >= 4) && (t <= 14) && (t % 2 == 0)));
        end
        chk("bubble_queue_left", mq.size(), 32'd0);

        // Reset with ops in flight: outputs clear at once, then a fresh op completes normally.
        for (int t = 0; t < 5; t++) cyc(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_zero", {31'd0, zero}, 32'd1);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_sum", {16'd0, sum}, 32'd0);
        chk("mid_rst_flags", {28'd0, cout, ovf, zero, neg}, 32'd0);
        mq.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        cyc(1'b1, 16'd100, 16'd50, 1'b1, 1'b1, 1'b1);
        for (int j = 1; j <= 4; j++) begin
            cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("post_rst_lat%0d", j), {31'd0, out_valid}, 32'(j == 4));
        end
        chk("post_rst_sum", {16'd0, sum}, 32'd50);

        all_done = 1'b0;
        for (int i = 0; i < 30000 && !all_done; i++) begin
            @(posedge clk);
            all_done = g_rnd[0].done && g_rnd[1].done && g_rnd[2].done;
        end
        chk("rnd_finished", {31'd0, all_done}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
